// File: rtl/bla_serial_sub_if.sv
// bla_serial_sub_if: start/done bus of the serial subtractor.
//   master : drives start, a, b, bin; observes ready, busy, done, diff, bout
//   slave  : the subtractor side
// With SUB_FLAGS_EN defined the result also carries the zero and ovf flags.
//
// Handshake: an operation is accepted on a rising clk edge where start=1 and
// ready=1. ready is high only while idle. Outside that edge start is ignored.
// The result on diff/bout (and the flags) is valid while done=1. done is a
// single-cycle pulse, and the result holds until the next completion.
interface bla_serial_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (output start, a, b, bin,
                  input  ready, busy, done, diff, bout, zero, ovf);
  modport slave  (input  start, a, b, bin,
                  output ready, busy, done, diff, bout, zero, ovf);
`else
  modport master (output start, a, b, bin,
                  input  ready, busy, done, diff, bout);
  modport slave  (input  start, a, b, bin,
                  output ready, busy, done, diff, bout);
`endif
endinterface

// File: rtl/bla_serial_sub.sv
// bla_serial_sub: iterative WIDTH-bit subtractor, diff = a - b - bin.
// One 4-bit borrow-lookahead slice is evaluated per clock, LSB slice first.
// The borrow passes from one slice to the next through a register.
// The optional SUB_FLAGS_EN macro adds the registered zero/ovf flags.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   bus       bla_serial_sub_if.slave (start, a, b, bin / ready, busy,
//             done, diff, bout [, zero, ovf])
//   dbg_state current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation
//
// Timing: IDLE -> RUN for exactly N=WIDTH/4 cycles -> DONE for one cycle ->
// IDLE. One operation completes every N+2 cycles.
module bla_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  bla_serial_sub_if.slave    bus,
  output logic [1:0]         dbg_state
);
  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // The operands shift right by one slice per RUN cycle, so the active slice
  // always sits in bits [3:0]. The result fills from the top, and after N
  // cycles slice 0 has reached the bottom.
  logic [WIDTH-1:0] op_a, op_b, res;
  logic             br;
  logic [IDXW-1:0]  idx;
  logic             msb_a, msb_b;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
`ifdef SUB_FLAGS_EN
  logic             zero_r, ovf_r;
`endif

  logic             ready_c, busy_c, done_c;
  logic             last_slice;

  assign last_slice = (idx == IDXW'(N - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_slice) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- 4-bit borrow-lookahead slice ----------------
  logic [3:0] sa, sb, g, p, d;
  logic       br1, br2, br3, br4;

  always_comb begin
    sa = op_a[3:0];
    sb = op_b[3:0];
    g  = ~sa & sb;       // this bit borrows on its own
    p  = ~(sa ^ sb);     // this bit passes an incoming borrow through
    br1 = g[0] | (p[0] & br);
    br2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br);
    br3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
          (p[2] & p[1] & p[0] & br);
    br4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
          (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & br);
    d   = sa ^ sb ^ {br3, br2, br1, br};
  end

  // Shift the new slice in at the top. Building the value this way keeps
  // the expression legal when WIDTH = 4.
  logic [WIDTH+3:0] res_cat;
  logic [WIDTH-1:0] res_nxt;
  assign res_cat = {d, res};
  assign res_nxt = res_cat[WIDTH+3:4];

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      br     <= 1'b0;
      idx    <= '0;
      msb_a  <= 1'b0;
      msb_b  <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
`ifdef SUB_FLAGS_EN
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            br    <= bus.bin;
            res   <= '0;
            idx   <= '0;
            msb_a <= bus.a[WIDTH-1];
            msb_b <= bus.b[WIDTH-1];
          end
        end
        RUN: begin
          op_a <= op_a >> 4;
          op_b <= op_b >> 4;
          br   <= br4;
          res  <= res_nxt;
          idx  <= idx + IDXW'(1);
          // diff/bout change only here, as the FSM moves into DONE.
          if (last_slice) begin
            diff_r <= res_nxt;
            bout_r <= br4;
`ifdef SUB_FLAGS_EN
            zero_r <= (res_nxt == '0);
            ovf_r  <= (msb_a != msb_b) && (res_nxt[WIDTH-1] != msb_a);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = ready_c;
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.diff  = diff_r;
  assign bus.bout  = bout_r;
`ifdef SUB_FLAGS_EN
  assign bus.zero  = zero_r;
  assign bus.ovf   = ovf_r;
`endif
  assign dbg_state = state;
endmodule

// File: tb/tb_bla_serial_sub.sv
module tb_bla_serial_sub;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;
`ifdef SUB_FLAGS_EN
  localparam int EW = WIDTH + 3;   // {ovf, zero, bout, diff}
`else
  localparam int EW = WIDTH + 1;   // {bout, diff}
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bla_serial_sub_if #(.WIDTH(WIDTH)) bus_if ();
  logic [1:0] dbg_state;

  bla_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works from the plain integer meaning of the operands.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic bin);
    longint ua, ub, r, sa, sb, s;
    logic [WIDTH-1:0] d;
    logic bo;
    ua = longint'(a);
    ub = longint'(b);
    r  = ua - ub - longint'(bin);
    if (r < 0) r = r + (longint'(1) <<< WIDTH);
    d  = r[WIDTH-1:0];
    bo = (ua < ub + longint'(bin));
`ifdef SUB_FLAGS_EN
    sa = a[WIDTH-1] ? ua - (longint'(1) <<< WIDTH) : ua;
    sb = b[WIDTH-1] ? ub - (longint'(1) <<< WIDTH) : ub;
    s  = sa - sb - longint'(bin);
    return {(s < -(longint'(1) <<< (WIDTH-1))) || (s > ((longint'(1) <<< (WIDTH-1)) - 1)),
            (d == '0), bo, d};
`else
    sa = 0; sb = 0; s = 0;
    return {bo, d};
`endif
  endfunction

  // ---------------- driver ----------------
  // Returns just after the accepting edge (+1), with start already low and
  // the operand inputs scrambled.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input bit push);
    int t = 0;
    while (!bus_if.ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!bus_if.ready) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout: ready stayed 0 for %0d cycles", t);
    end
    bus_if.start = 1'b1;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.bin   = bin;
    if (push) exp_q.push_back(model(a, b, bin));
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.a     = WIDTH'($urandom);
    bus_if.b     = WIDTH'($urandom);
    bus_if.bin   = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!bus_if.done && t < 50) begin
      @(negedge clk); t++;
    end
    check(name, {31'd0, bus_if.done}, 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus_if.done) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL result_unexpected: done with diff=0x%0h, none expected", bus_if.diff);
      end else begin
        logic [EW-1:0] e;
        logic [EW-1:0] act;
        e = exp_q.pop_front();
`ifdef SUB_FLAGS_EN
        act = {bus_if.ovf, bus_if.zero, bus_if.bout, bus_if.diff};
`else
        act = {bus_if.bout, bus_if.diff};
`endif
        check("result", 32'(act), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, bus_if.ready}, 32'd1);
    check("rst_busy",  {31'd0, bus_if.busy},  32'd0);
    check("rst_done",  {31'd0, bus_if.done},  32'd0);
    check("rst_diff",  32'(bus_if.diff), 32'd0);
    check("rst_bout",  {31'd0, bus_if.bout},  32'd0);

    // 1: latency and handshake timing
    start_op(16'h1234, 16'h0234, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("t1_busy", {30'd0, bus_if.busy, bus_if.done}, 32'd2);
      check("t1_diff_hold", 32'(bus_if.diff), 32'd0);
    end
    @(negedge clk);
    check("t1_done", {30'd0, bus_if.done, bus_if.ready}, 32'd2);
    @(negedge clk);
    check("t1_ready_back", {30'd0, bus_if.ready, bus_if.done}, 32'd2);

    // 2-4: directed corner cases (checked by the monitor)
    start_op(16'h0000, 16'h0001, 1'b0, 1'b1); wait_done("t2_done");
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1); wait_done("t3_done");
    start_op(16'h5555, 16'h5555, 1'b1, 1'b1); wait_done("t4a_done");
    start_op(16'h5555, 16'h5555, 1'b0, 1'b1); wait_done("t4b_done");
    start_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b1); wait_done("t4c_done");

    // 5: start held high through RUN/DONE is ignored until ready returns
    start_op(16'h0010, 16'h0001, 1'b0, 1'b1);
    bus_if.start = 1'b1;
    bus_if.a     = 16'hFFFF;
    bus_if.b     = 16'hFFFF;
    bus_if.bin   = 1'b0;
    exp_q.push_back(model(16'hFFFF, 16'hFFFF, 1'b0));
    wait_done("t5a_done");
    check("t5a_diff", 32'(bus_if.diff), 32'h000F);
    @(posedge clk); #1;
    check("t5_ready", {31'd0, bus_if.ready}, 32'd1);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("t5b_busy", {31'd0, bus_if.busy}, 32'd1);
      check("t5b_diff_hold", 32'(bus_if.diff), 32'h000F);
    end
    wait_done("t5b_done");

    // randomized operations with random idle gaps
    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (n % 8 == 0) rb = ra;
      start_op(ra, rb, 1'($urandom), 1'b1);
      wait_done("rnd_done");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // 6: reset during the second RUN cycle aborts the operation
    start_op(16'h1234, 16'h0234, 1'b0, 1'b1); wait_done("t6_pre_done");
    start_op(16'h4321, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6_busy",  {31'd0, bus_if.busy},  32'd0);
    check("t6_ready", {31'd0, bus_if.ready}, 32'd1);
    check("t6_diff",  32'(bus_if.diff), 32'd0);
    check("t6_bout",  {31'd0, bus_if.bout},  32'd0);
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      check("t6_no_done", {31'd0, bus_if.done}, 32'd0);
    end

    // all expected results consumed
    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 50) begin
        @(negedge clk); t++;
      end
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
